// File: rtl/register_writeback_if.sv
// Writeback-stage bus: ALU result path, load-unit valid/ready path and register-file write port.
// slave = writeback stage, master = producers/consumer around it.
interface register_writeback_if;
  logic        i_AluValid;
  logic [4:0]  i_AluRegDest;
  logic [31:0] i_AluData;
  logic        i_LoadValid;
  logic        o_LoadReady;
  logic [4:0]  i_LoadRegDest;
  logic [31:0] i_LoadData;
  logic        o_WriteEnable;
  logic [4:0]  o_RegDest;
  logic [31:0] o_DataOut;
  logic [31:0] o_PendingMask;
  logic        o_AluHold;

  // Load handshake: a load transfers on a cycle where i_LoadValid and o_LoadReady are both 1;
  // o_LoadReady depends on registered state only and never on i_LoadValid.
  modport slave (
    input  i_AluValid, i_AluRegDest, i_AluData,
    input  i_LoadValid, i_LoadRegDest, i_LoadData,
    output o_LoadReady,
    output o_WriteEnable, o_RegDest, o_DataOut,
    output o_PendingMask, o_AluHold
  );

  modport master (
    output i_AluValid, i_AluRegDest, i_AluData,
    output i_LoadValid, i_LoadRegDest, i_LoadData,
    input  o_LoadReady,
    input  o_WriteEnable, o_RegDest, o_DataOut,
    input  o_PendingMask, o_AluHold
  );
endinterface

// File: rtl/register_writeback.sv
// Writeback stage: merges the non-stallable ALU path and a buffered load path onto one
// register-file write port, exporting a pending-destination mask and an ALU hold request.
module register_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  register_writeback_if.slave   wbIf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifoDest [DEPTH];
  logic [31:0]   fifoData [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [SW-1:0] starveCount;

  logic        writeEnable;
  logic [4:0]  regDest;
  logic [31:0] dataOut;
  logic [31:0] pendingMask;

  logic aluQual;
  logic fifoEmpty;
  logic fifoFull;
  logic loadAccept;
  logic loadDrop;
  logic bypass;
  logic enq;
  logic deq;

  assign aluQual    = wbIf.i_AluValid && (wbIf.i_AluRegDest != 5'd0);
  assign fifoEmpty  = (count == '0);
  assign fifoFull   = (count == CW'(DEPTH));
  assign loadAccept = wbIf.i_LoadValid && !fifoFull;
  assign loadDrop   = (wbIf.i_LoadRegDest == 5'd0);
  // An empty FIFO with an idle port lets the load go straight through, never touching storage.
  assign bypass     = fifoEmpty && loadAccept && !loadDrop && !aluQual;
  assign enq        = loadAccept && !loadDrop && !bypass;
  assign deq        = !aluQual && !fifoEmpty;

  always_ff @(posedge i_Clock) begin
    if (enq) begin
      fifoDest[wrPtr] <= wbIf.i_LoadRegDest;
      fifoData[wrPtr] <= wbIf.i_LoadData;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + PW'(1);
      if (deq) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      writeEnable <= 1'b0;
      regDest     <= 5'd0;
      dataOut     <= 32'd0;
    end else if (aluQual) begin
      writeEnable <= 1'b1;
      regDest     <= wbIf.i_AluRegDest;
      dataOut     <= wbIf.i_AluData;
    end else if (deq) begin
      writeEnable <= 1'b1;
      regDest     <= fifoDest[rdPtr];
      dataOut     <= fifoData[rdPtr];
    end else if (bypass) begin
      writeEnable <= 1'b1;
      regDest     <= wbIf.i_LoadRegDest;
      dataOut     <= wbIf.i_LoadData;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  // Counts ALU wins over a waiting head; a drain or an empty FIFO resets it.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      starveCount <= '0;
    end else if (fifoEmpty || deq) begin
      starveCount <= '0;
    end else if (aluQual && (starveCount != SW'(STARVE_LIMIT))) begin
      starveCount <= starveCount + SW'(1);
    end
  end

  always_comb begin
    pendingMask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) pendingMask[fifoDest[rdPtr + PW'(i)]] = 1'b1;
    end
    pendingMask[0] = 1'b0;
  end

  assign wbIf.o_LoadReady   = !fifoFull;
  assign wbIf.o_WriteEnable = writeEnable;
  assign wbIf.o_RegDest     = regDest;
  assign wbIf.o_DataOut     = dataOut;
  assign wbIf.o_PendingMask = pendingMask;
  assign wbIf.o_AluHold     = (starveCount == SW'(STARVE_LIMIT));

endmodule

// File: doc/register_writeback.md
# register_writeback

Writeback stage driving the core's single register-file write port (write enable, 5-bit destination, 32-bit data). It merges two result producers: the single-cycle ALU path, which cannot stall, and the variable-latency load unit, which uses a valid/ready handshake. Load results are held in a small in-order FIFO and drained into idle write-port cycles. The block also exports a pending-destination mask that the hazard logic uses to stall reads of registers with a buffered load.

## Interface
- DEPTH, 2: load FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4: consecutive ALU-winning cycles with a non-empty FIFO before hold is requested; ≥1

Ports:
- i_Clock  in  1  clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_AluValid  in  1  ALU result present this cycle
- i_AluRegDest  in  5  ALU destination register
- i_AluData  in  32  ALU result
- i_LoadValid  in  1  load result offered
- o_LoadReady  out  1  FIFO can accept a load this cycle
- i_LoadRegDest  in  5  load destination register
- i_LoadData  in  32  load data
- o_WriteEnable  out  1  register-file write enable (registered)
- o_RegDest  out  5  register-file destination (registered)
- o_DataOut  out  32  register-file write data (registered)
- o_PendingMask  out  32  bit r = a buffered load targets xr; bit 0 is always 0
- o_AluHold  out  1  request upstream to bubble the ALU path

## Operation
- ALU write qualifies when i_AluValid=1 and i_AluRegDest≠0. A qualifying ALU write always owns the write port this cycle.
- Load accept: i_LoadValid & o_LoadReady.
  - o_LoadReady = !full, from registered state only.
  - A slot freed by a same-cycle dequeue does not raise ready when the FIFO is full.
  - An accepted load with dest 0 is consumed and dropped; no FIFO entry.
- Drain: if no qualifying ALU write and the FIFO is non-empty, the head is written and dequeued.
- Empty-FIFO bypass: if the FIFO is empty, a load is accepted and no ALU write qualifies, the load is written directly, same as enqueue plus dequeue. FIFO stays empty.
- Otherwise, write-port registers load o_WriteEnable=0; o_RegDest and o_DataOut hold their previous values.
- Loads are written strictly in acceptance order. ALU and load writes to the same register resolve in port order. Upstream uses o_PendingMask to prevent WAW/RAW hazards.
- o_PendingMask:
  - Combinational OR over valid FIFO entries of the one-hot destination.
  - An entry dequeued this cycle still counts this cycle.
  - Bypassed loads never appear.
- Starvation counter:
  - Increments each cycle with the FIFO non-empty and a qualifying ALU write.
  - Clears whenever a FIFO dequeue occurs or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - o_AluHold = (count == STARVE_LIMIT).
  - If the ALU still presents a qualifying write while hold is asserted, the ALU still wins (upstream violation; no data loss, counter stays saturated).
- FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit or count.

## Timing
- Reset (async assert, sync deassert by the system) sets:
  - o_WriteEnable=0, o_RegDest=0, o_DataOut=0.
  - FIFO empty, so o_LoadReady=1 and o_PendingMask=0.
  - Counter=0, so o_AluHold=0.
  - All buffered loads are discarded.
- Reset asserted mid-drain: o_WriteEnable drops immediately. No partial write is emitted after release.
- Latency, input to o_WriteEnable:
  - Qualifying ALU write: 1 cycle.
  - Bypassed load: 1 cycle.
  - Buffered load: 1 cycle after the first cycle with no qualifying ALU write once it is at the head.
- Throughput: one register write per cycle maximum. With DEPTH=2 a continuous load stream is accepted every cycle while the ALU is idle.
- o_LoadReady, o_PendingMask and o_AluHold change only after clock edges. They have no combinational path from i_* inputs.

## Test plan
- Reset: assert i_Reset mid-cycle with 2 loads buffered. Outputs go to 0 asynchronously, o_LoadReady=1, mask=0. No write occurs after release.
- ALU priority and bypass:
  - ALU x5=0x11 and load x6=0x22 in the same cycle with an empty FIFO. Next cycle: write x5=0x11 and mask bit 6 set.
  - Following idle cycle: write x6=0x22 and mask=0.
- Full FIFO (DEPTH=2): continuous ALU writes plus loads x1,x2,x3.
  - x1 and x2 are accepted; o_LoadReady=0 and x3 is held.
  - ALU goes idle: x1, then x2, then x3 are written in consecutive cycles, in order.
- Dest-zero:
  - ALU x0 with load x7=0x33 on an empty FIFO → next cycle writes x7=0x33 (bypass).
  - Load x0 alone → accepted, o_WriteEnable stays 0, no mask bit.
- Starvation (STARVE_LIMIT=4): one buffered load plus 4 consecutive qualifying ALU writes.
  - o_AluHold rises after the 4th.
  - ALU idle next cycle → the load is written, and o_AluHold falls the following cycle.
- Wrap-around: 10 loads with a varying ALU pattern. Every load is written exactly once, in order, with the correct data across pointer wrap.
